// File: rtl/iob_sp_ram_arb.sv
// Round-robin arbiter and sequencer in front of one single-port synchronous RAM.
// After reset it can zero-fill the RAM, then serves two requesters with a fixed 1-cycle read latency.
module iob_sp_ram_arb #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,

  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic {StClear, StRun} state_e;

  localparam state_e          ResetState = (INIT_CLEAR != 0) ? StClear : StRun;
  localparam logic [ADDR_W:0] LastAddr   = {1'b0, {ADDR_W{1'b1}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  // Last requester granted: 0 = A, 1 = B. Resets to B so A wins the first tie.
  logic              rr_q, rr_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;

  logic              grant_a, grant_b;
  logic              en_c, we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] din_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ResetState;
      cnt_q      <= '0;
      rr_q       <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    en_c       = 1'b0;
    we_c       = 1'b0;
    addr_c     = '0;
    din_c      = '0;

    unique case (state_q)
      StClear: begin
        en_c   = 1'b1;
        we_c   = 1'b1;
        addr_c = cnt_q[ADDR_W-1:0];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StRun;
        end
      end
      StRun: begin
        grant_a = a_valid & (~b_valid | rr_q);
        grant_b = b_valid & ~grant_a;
        if (grant_a) begin
          en_c   = 1'b1;
          we_c   = a_we;
          addr_c = a_addr;
          din_c  = a_wdata;
          rr_d   = 1'b0;
        end else if (grant_b) begin
          en_c   = 1'b1;
          we_c   = b_we;
          addr_c = b_addr;
          din_c  = b_wdata;
          rr_d   = 1'b1;
        end
      end
      default: state_d = ResetState;
    endcase

    a_rvalid_d = grant_a & ~a_we;
    b_rvalid_d = grant_b & ~b_we;
  end

  // Reset gates the handshake and the RAM port combinationally so nothing escapes while rst is high.
  assign ram_en    = en_c & ~rst;
  assign ram_we    = we_c;
  assign ram_addr  = addr_c;
  assign ram_din   = din_c;

  assign a_ready   = grant_a & ~rst;
  assign b_ready   = grant_b & ~rst;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = ram_dout;
  assign b_rdata   = ram_dout;
  assign init_done = (state_q == StRun);

endmodule
